// File: rtl/btb_assoc_if.sv
// Fetch/train/predict bundle for btb_assoc. Define BTB_STATS_EN to add the statistics outputs.
interface btb_assoc_if;
   logic        i_flush;
   logic        i_update;
   logic [31:0] i_upd_pc;
   logic [31:0] i_upd_target;
   logic        i_upd_taken;
   logic        i_fetch;
   logic [31:0] i_fetch_pc;
   logic [31:0] o_predict_pc;
   logic        o_predict_valid;
   logic        o_predict_taken;
`ifdef BTB_STATS_EN
   logic [31:0] o_stat_lookups;
   logic [31:0] o_stat_hits;
`endif

   modport master (
      output i_flush, i_update, i_upd_pc, i_upd_target, i_upd_taken, i_fetch, i_fetch_pc,
      input  o_predict_pc, o_predict_valid, o_predict_taken
`ifdef BTB_STATS_EN
      , input o_stat_lookups, o_stat_hits
`endif
   );

   modport slave (
      input  i_flush, i_update, i_upd_pc, i_upd_target, i_upd_taken, i_fetch, i_fetch_pc,
      output o_predict_pc, o_predict_valid, o_predict_taken
`ifdef BTB_STATS_EN
      , output o_stat_lookups, o_stat_hits
`endif
   );
endinterface

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer: saturating direction counters, per-set round-robin
// replacement, single-cycle flush. Define BTB_STATS_EN for saturating lookup/hit counters.
module btb_assoc #(
   parameter int BTB_SETS = 16,
   parameter int BTB_WAYS = 2,
   parameter int CTR_W    = 2
) (
   input logic        clk,
   input logic        rst,
   btb_assoc_if.slave bus
);
   localparam int IW    = $clog2(BTB_SETS);
   localparam int TAG_W = 30 - IW;
   localparam int WW    = $clog2(BTB_WAYS);
   localparam logic [CTR_W-1:0] CTR_MAX  = '1;
   localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(1) << (CTR_W - 1);

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [29:0]      target;
      logic [CTR_W-1:0] ctr;
   } entry_t;

   logic [BTB_WAYS-1:0] r_valid [BTB_SETS];
   logic [WW-1:0]       r_vp    [BTB_SETS];
   entry_t              r_entry [BTB_SETS][BTB_WAYS];

   logic [IW-1:0]    w_f_idx, w_u_idx;
   logic [TAG_W-1:0] w_f_tag, w_u_tag;
   logic             w_f_hit, w_u_hit, w_u_free;
   logic [WW-1:0]    w_f_way, w_u_way, w_u_free_way, w_victim;
   entry_t           w_f_entry, w_u_entry;
   logic [CTR_W-1:0] w_ctr_next;
   logic             w_unused;

   assign w_f_idx  = bus.i_fetch_pc[2 +: IW];
   assign w_f_tag  = bus.i_fetch_pc[31:2+IW];
   assign w_u_idx  = bus.i_upd_pc[2 +: IW];
   assign w_u_tag  = bus.i_upd_pc[31:2+IW];
   assign w_unused = &{1'b0, bus.i_fetch_pc[1:0], bus.i_upd_pc[1:0], bus.i_upd_target[1:0]};

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      w_f_hit = 1'b0;
      w_f_way = '0;
      w_u_hit = 1'b0;
      w_u_way = '0;
      for (int w = 0; w < BTB_WAYS; w++) begin
         if (r_valid[w_f_idx][w] && r_entry[w_f_idx][w].tag == w_f_tag) begin
            w_f_hit = 1'b1;
            w_f_way = WW'(w);
         end
         if (r_valid[w_u_idx][w] && r_entry[w_u_idx][w].tag == w_u_tag) begin
            w_u_hit = 1'b1;
            w_u_way = WW'(w);
         end
      end
   end

   // Downward scan so the lowest-numbered invalid way wins.
   always_comb begin
      w_u_free     = 1'b0;
      w_u_free_way = '0;
      for (int w = BTB_WAYS - 1; w >= 0; w--) begin
         if (!r_valid[w_u_idx][w]) begin
            w_u_free     = 1'b1;
            w_u_free_way = WW'(w);
         end
      end
   end

   assign w_victim  = w_u_free ? w_u_free_way : r_vp[w_u_idx];
   assign w_f_entry = r_entry[w_f_idx][w_f_way];
   assign w_u_entry = r_entry[w_u_idx][w_u_way];

   always_comb begin
      w_ctr_next = w_u_entry.ctr;
      if (bus.i_upd_taken && w_u_entry.ctr != CTR_MAX)
         w_ctr_next = w_u_entry.ctr + CTR_W'(1);
      else if (!bus.i_upd_taken && w_u_entry.ctr != '0)
         w_ctr_next = w_u_entry.ctr - CTR_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst || bus.i_flush) begin
         for (int s = 0; s < BTB_SETS; s++) begin
            r_valid[s] <= '0;
            r_vp[s]    <= '0;
         end
      end else if (bus.i_update && !w_u_hit && bus.i_upd_taken) begin
         r_valid[w_u_idx][w_victim] <= 1'b1;
         if (!w_u_free)
            r_vp[w_u_idx] <= r_vp[w_u_idx] + WW'(1);
      end
   end

   // NOTE: payload storage has no reset; valid bits alone decide whether an entry is visible.
   always_ff @(posedge clk) begin
      if (!rst && !bus.i_flush && bus.i_update) begin
         if (w_u_hit) begin
            r_entry[w_u_idx][w_u_way].ctr <= w_ctr_next;
            if (bus.i_upd_taken)
               r_entry[w_u_idx][w_u_way].target <= bus.i_upd_target[31:2];
         end else if (bus.i_upd_taken) begin
            r_entry[w_u_idx][w_victim] <= {w_u_tag, bus.i_upd_target[31:2], CTR_INIT};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.o_predict_valid <= 1'b0;
         bus.o_predict_pc    <= '0;
         bus.o_predict_taken <= 1'b0;
      end else if (bus.i_fetch) begin
         bus.o_predict_valid <= w_f_hit;
         bus.o_predict_pc    <= w_f_hit ? {w_f_entry.target, 2'b00} : 32'h0;
         bus.o_predict_taken <= w_f_hit & w_f_entry.ctr[CTR_W-1];
      end
   end

`ifdef BTB_STATS_EN
   always_ff @(posedge clk) begin
      if (rst || bus.i_flush) begin
         bus.o_stat_lookups <= '0;
         bus.o_stat_hits    <= '0;
      end else if (bus.i_fetch) begin
         if (bus.o_stat_lookups != 32'hFFFF_FFFF)
            bus.o_stat_lookups <= bus.o_stat_lookups + 32'd1;
         if (w_f_hit && bus.o_stat_hits != 32'hFFFF_FFFF)
            bus.o_stat_hits <= bus.o_stat_hits + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_btb_assoc.sv
// Directed scoreboard bench for btb_assoc: lookups push expected predictions, a monitor
// compares one cycle later. Statistics checks compile in when BTB_STATS_EN is defined.
module tb_btb_assoc;
   typedef struct packed {
      logic        v;
      logic [31:0] pc;
      logic        tk;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic r_fetch_d = 1'b0;
   int   total = 0;
   int   bad   = 0;
   exp_t exp_q[$];

   btb_assoc_if bus ();

   btb_assoc #(.BTB_SETS(16), .BTB_WAYS(2), .CTR_W(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   always @(posedge clk) r_fetch_d <= bus.i_fetch;

   always @(negedge clk) begin
      if (r_fetch_d) begin
         if (exp_q.size() == 0) begin
            check("scoreboard_underflow", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("predict_valid", {31'd0, bus.o_predict_valid}, {31'd0, e.v});
            check("predict_pc", bus.o_predict_pc, e.pc);
            check("predict_taken", {31'd0, bus.o_predict_taken}, {31'd0, e.tk});
         end
      end
   end

   task automatic idle_inputs();
      bus.i_flush      = 1'b0;
      bus.i_update     = 1'b0;
      bus.i_upd_pc     = '0;
      bus.i_upd_target = '0;
      bus.i_upd_taken  = 1'b0;
      bus.i_fetch      = 1'b0;
      bus.i_fetch_pc   = '0;
   endtask

   task automatic cyc(input logic fl, input logic up, input logic [31:0] upc,
                      input logic [31:0] utgt, input logic utk, input logic fe,
                      input logic [31:0] fpc, input logic ev, input logic [31:0] epc,
                      input logic etk);
      bus.i_flush      = fl;
      bus.i_update     = up;
      bus.i_upd_pc     = upc;
      bus.i_upd_target = utgt;
      bus.i_upd_taken  = utk;
      bus.i_fetch      = fe;
      bus.i_fetch_pc   = fpc;
      if (fe) exp_q.push_back('{v: ev, pc: epc, tk: etk});
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
      cyc(1'b0, 1'b1, pc, tgt, tk, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic fet(input logic [31:0] pc, input logic ev, input logic [31:0] epc,
                      input logic etk);
      cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, pc, ev, epc, etk);
   endtask

   task automatic check_outputs_reset(input string tag);
      check({tag, "_valid"}, {31'd0, bus.o_predict_valid}, 32'd0);
      check({tag, "_pc"}, bus.o_predict_pc, 32'd0);
      check({tag, "_taken"}, {31'd0, bus.o_predict_taken}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      idle_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check_outputs_reset("reset");

      // Basic miss, allocate, hit, hold.
      fet(32'h0000_1000, 1'b0, 32'h0, 1'b0);
      upd(32'h0000_1000, 32'h0000_2000, 1'b1);
      fet(32'h0000_1000, 1'b1, 32'h0000_2000, 1'b1);
      cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      check("hold_pc", bus.o_predict_pc, 32'h0000_2000);
      check("hold_taken", {31'd0, bus.o_predict_taken}, 32'd1);

      // Counter: 10 -> 01 -> 00 -> 00, then taken 01 with new target, then 10.
      repeat (3) upd(32'h0000_1000, 32'h0000_9000, 1'b0);
      fet(32'h0000_1000, 1'b1, 32'h0000_2000, 1'b0);
      upd(32'h0000_1000, 32'h0000_3000, 1'b1);
      fet(32'h0000_1000, 1'b1, 32'h0000_3000, 1'b0);
      upd(32'h0000_1000, 32'h0000_3000, 1'b1);
      fet(32'h0000_1000, 1'b1, 32'h0000_3000, 1'b1);

      // Flush with same-cycle fetch sees old data; next fetch misses.
      cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0000_1000, 1'b1, 32'h0000_3000, 1'b1);
      fet(32'h0000_1000, 1'b0, 32'h0, 1'b0);

      // Replacement in set 0: free ways first, then round-robin victim.
      upd(32'h0000_1000, 32'h0000_0100, 1'b1);
      upd(32'h0000_1040, 32'h0000_0200, 1'b1);
      upd(32'h0000_1080, 32'h0000_0300, 1'b1);
      fet(32'h0000_1000, 1'b0, 32'h0, 1'b0);
      fet(32'h0000_1040, 1'b1, 32'h0000_0200, 1'b1);
      fet(32'h0000_1080, 1'b1, 32'h0000_0300, 1'b1);
      upd(32'h0000_10C0, 32'h0000_0400, 1'b1);
      fet(32'h0000_1040, 1'b0, 32'h0, 1'b0);
      fet(32'h0000_1080, 1'b1, 32'h0000_0300, 1'b1);
      fet(32'h0000_10C0, 1'b1, 32'h0000_0400, 1'b1);

      // Not-taken miss allocates nothing.
      upd(32'h0000_1000, 32'h0000_0100, 1'b0);
      fet(32'h0000_1000, 1'b0, 32'h0, 1'b0);

      // Same-cycle allocate and fetch: miss now, hit next.
      cyc(1'b0, 1'b1, 32'h0000_2004, 32'h0000_5000, 1'b1, 1'b1, 32'h0000_2004, 1'b0, 32'h0, 1'b0);
      fet(32'h0000_2004, 1'b1, 32'h0000_5000, 1'b1);

      // Victim pointer wrapped back to way 0, so 0x1080 is evicted.
      upd(32'h0000_1040, 32'h0000_0700, 1'b1);
      fet(32'h0000_1040, 1'b1, 32'h0000_0700, 1'b1);
      fet(32'h0000_1080, 1'b0, 32'h0, 1'b0);

      // Flush beats a same-cycle update; same-cycle fetch still hits old entry.
      cyc(1'b1, 1'b1, 32'h0000_1040, 32'h0000_0800, 1'b1, 1'b1, 32'h0000_1040, 1'b1, 32'h0000_0700, 1'b1);
`ifdef BTB_STATS_EN
      check("stat_lookups_flush", bus.o_stat_lookups, 32'd0);
      check("stat_hits_flush", bus.o_stat_hits, 32'd0);
`endif
      fet(32'h0000_1040, 1'b0, 32'h0, 1'b0);
      fet(32'h0000_10C0, 1'b0, 32'h0, 1'b0);
      upd(32'h0000_2004, 32'h0000_5000, 1'b1);
      fet(32'h0000_2004, 1'b1, 32'h0000_5000, 1'b1);
`ifdef BTB_STATS_EN
      check("stat_lookups", bus.o_stat_lookups, 32'd3);
      check("stat_hits", bus.o_stat_hits, 32'd1);
`endif

      // Mid-run reset clears outputs and entries.
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_outputs_reset("midrst");
`ifdef BTB_STATS_EN
      check("stat_lookups_rst", bus.o_stat_lookups, 32'd0);
`endif
      fet(32'h0000_2004, 1'b0, 32'h0, 1'b0);

      repeat (2) @(posedge clk);
      #1;
      check("scoreboard_drain", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
